// File: rtl/bitonic_sorter_stream_if.sv
// Valid/ready stream bundle for the bitonic sorter: one N-word array per beat
// plus the sort-direction bit that travels with it.
interface bitonic_sorter_stream_if #(
    parameter int DATA_W = 32,
    parameter int LOG_N  = 3
);
    localparam int N = 1 << LOG_N;

    logic              in_valid_i;
    logic              in_ready_o;
    logic              desc_i;
    logic [DATA_W-1:0] array_i [N];
    logic              out_valid_o;
    logic              out_ready_i;
    logic              desc_o;
    logic [DATA_W-1:0] array_o [N];

    modport master (
        output in_valid_i, desc_i, array_i, out_ready_i,
        input  in_ready_o, out_valid_o, desc_o, array_o
    );

    modport slave (
        input  in_valid_i, desc_i, array_i, out_ready_i,
        output in_ready_o, out_valid_o, desc_o, array_o
    );
endinterface

// File: rtl/bitonic_sorter_stream.sv
// Fully pipelined bitonic sorting network, one compare-exchange rank per
// register stage, with a single global advance for backpressure.
module bitonic_sorter_stream #(
    parameter int DATA_W = 32,
    parameter int LOG_N  = 3,
    parameter bit SIGNED = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    bitonic_sorter_stream_if.slave bus
);
    localparam int N      = 1 << LOG_N;
    localparam int STAGES = LOG_N * (LOG_N + 1) / 2;

    typedef logic [DATA_W-1:0] word_t;

    word_t             data_q [STAGES][N];
    word_t             data_d [STAGES][N];
    word_t             net    [STAGES][N];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] desc_q;
    logic [STAGES-1:0] desc_d;
    logic [STAGES-1:0] desc_src;
    logic              adv;

    function automatic logic gt(input word_t a, input word_t b);
        if (SIGNED) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Bit s of desc_src is the direction of the array entering stage s.
    always_comb begin
        adv      = bus.out_ready_i | ~valid_q[STAGES-1];
        desc_src = (desc_q << 1) | STAGES'(bus.desc_i);
        valid_d  = valid_q;
        desc_d   = desc_q;
        if (adv) begin
            valid_d = (valid_q << 1) | STAGES'(bus.in_valid_i);
            desc_d  = desc_src;
        end
    end

    always_comb begin
        data_d = data_q;
        if (adv) data_d = net;
    end

    for (genvar p = 1; p <= LOG_N; p++) begin : g_k
        for (genvar r = 0; r < p; r++) begin : g_j
            localparam int S = p * (p - 1) / 2 + r;
            localparam int K = 1 << p;
            localparam int J = 1 << (p - 1 - r);

            word_t src [N];

            if (S == 0) begin : g_in
                assign src = bus.array_i;
            end else begin : g_pipe
                assign src = data_q[S-1];
            end

            for (genvar i = 0; i < N; i++) begin : g_cx
                if ((i & J) == 0) begin : g_pair
                    localparam bit ASC = ((i & K) == 0);
                    logic swap;
                    // Equal operands never swap.
                    assign swap = (ASC ^ desc_src[S])
                                ? gt(src[i], src[i|J])
                                : gt(src[i|J], src[i]);
                    assign net[S][i]   = swap ? src[i|J] : src[i];
                    assign net[S][i|J] = swap ? src[i]   : src[i|J];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int i = 0; i < N; i++) begin
                    data_q[s][i] <= '0;
                end
            end
            valid_q <= '0;
            desc_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            desc_q  <= desc_d;
        end
    end

    assign bus.in_ready_o  = adv;
    assign bus.out_valid_o = valid_q[STAGES-1];
    assign bus.desc_o      = desc_q[STAGES-1];
    assign bus.array_o     = data_q[STAGES-1];
endmodule

// File: doc/bitonic_sorter_stream.md
# bitonic_sorter_stream

Parametrised, fully pipelined bitonic sorting network for N = 2^LOG_N words of DATA_W bits, with per-transaction sort direction and a valid/ready handshake with backpressure. One complete array is accepted per cycle and sorted arrays are emitted in order after a fixed latency. It sits between a producer and a consumer that both speak valid/ready, and is the general successor of the fixed 8-word, free-running sorter.

## Interface
- DATA_W, 32, element width in bits (≥2)
- LOG_N, 3, log2 of element count; N = 2^LOG_N (1..5)
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- STAGES (localparam), LOG_N*(LOG_N+1)/2, compare-exchange stage count (6 for LOG_N=3)

Ports:
- clk_i  in  1  clock; all registers on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  input array valid
- in_ready_o  out  1  block can accept this cycle
- desc_i  in  1  0 = ascending, 1 = descending; sampled with the array
- array_i  in  N×DATA_W  unpacked array of N elements, index 0..N-1
- out_valid_o  out  1  output array valid
- out_ready_i  in  1  consumer accepts
- desc_o  out  1  direction bit that travelled with the array
- array_o  out  N×DATA_W  sorted array

## Operation
- Pipeline of STAGES register stages. Each stage holds an N-element data vector, a valid bit, and a direction bit.
- Global advance: adv = out_ready_i | ~out_valid_o. in_ready_o = adv (combinational from out_ready_i and out_valid_o).
- Input is accepted when in_valid_i & in_ready_o. When adv=1, every stage loads from its predecessor. Stage 0 valid loads in_valid_i.
- When adv=0, all stage registers (data, valid, direction) hold.
- Bubbles are not squeezed out; an empty stage still waits for adv.
- Network, for k = 2,4,..,N and within each k for j = k/2,..,1, one stage per (k,j):
  - For each i with (i & j) == 0, compare-exchange element i with element i|j.
  - Ascending pair when (i & k) == 0, else descending.
  - If the travelling desc bit is 1, invert every pair's sense.
  - Ascending pair: lower index receives min, higher index receives max.
- Compare uses $signed when SIGNED=1, unsigned otherwise.
- On equal values, no swap. Output is the same multiset either way.
- Stage data registers load on adv regardless of valid. Content of invalid stages is don't-care, except after reset.
- desc_o = direction bit of the last stage. array_o = data of the last stage.

## Timing
- Reset (async assert, released synchronously by design): all stage valid bits 0, all data 0, all direction bits 0. Resulting outputs: out_valid_o=0, array_o all 0, desc_o=0. in_ready_o=1 once rst_i is low (it is adv with out_valid_o=0).
- Latency: an array accepted at edge t appears with out_valid_o=1 after edge t+STAGES-1, i.e. STAGES cycles, provided no stall.
- Throughput: one array per cycle while out_ready_i=1.
- Stall: with out_valid_o=1 and out_ready_i=0, array_o, desc_o and out_valid_o hold stable. in_ready_o=0 and no input is taken.
- Simultaneous output consume and input accept in the same cycle is legal and required.
- Reset mid-operation: all in-flight arrays are discarded. No output appears until new input completes STAGES cycles.
- No combinational path from array_i to array_o.

## Test plan
- Ascending sort, N=8, DATA_W=32, SIGNED=1, desc_i=0, out_ready_i=1:
  - Stimulus: [5,-3,7,0,-8,2,2,1].
  - Required: exactly 6 cycles later out_valid_o=1, array_o=[-8,-3,0,1,2,2,5,7], desc_o=0.
- Descending sort, same data, desc_i=1:
  - Required: array_o=[7,5,2,2,1,0,-3,-8], desc_o=1.
- Unsigned mode, SIGNED=0:
  - Stimulus: [32'hFFFFFFFF,1,0,32'h80000000,3,3,2,7], ascending.
  - Required: array_o=[0,1,2,3,3,7,32'h80000000,32'hFFFFFFFF].
- Back-to-back streaming:
  - Stimulus: 20 random arrays on consecutive cycles with random desc_i.
  - Required: 20 outputs on consecutive cycles, in order, each matching a reference sort for its direction.
- Backpressure:
  - Stimulus: stream 10 arrays; hold out_ready_i=0 for 4 cycles mid-stream.
  - Required: array_o stable and in_ready_o=0 throughout the stall. No loss or duplication; order preserved.
- Reset mid-flight:
  - Stimulus: 3 arrays accepted, then rst_i pulsed asynchronously between edges.
  - Required: out_valid_o=0 immediately, array_o=0, in_ready_o=1 after release, none of the 3 arrays ever emitted.
- Parameter sweep: repeat the random test for LOG_N=1,2,4,5 with DATA_W=8. Latency must equal LOG_N*(LOG_N+1)/2.
